accu_seq_ctrl: RTL and testbench

ACCU_SEQ_CTRL -- requirements
Module: accu_seq_ctrl

---
 rtl/accu_pkg.sv | 22 ++
 rtl/accu_step_timer.sv | 28 ++
 rtl/accu_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_accu_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accu_pkg.sv
// Shared definitions for the accumulating sequence-detector controller.
// State encoding, timing constants and the length clamp helper.
package accu_pkg;

  localparam int RSTD_LEN = 2;
  localparam int MAX_LEN  = 16;
  localparam int TW       = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RSTD   = 3'd1,
    SETUP  = 3'd2,
    PULSE  = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  function automatic logic [4:0] clamp_len(input logic [4:0] l);
    return (l > 5'(MAX_LEN)) ? 5'(MAX_LEN) : l;
  endfunction

endpackage

// File: rtl/accu_step_timer.sv
// Loadable down-counter; zero flags the last cycle of a timed phase.
// Holds at zero until reloaded.
module accu_step_timer
  import accu_pkg::*;
#(
  parameter int W = TW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/accu_seq_ctrl.sv
// Plays a latched bit pattern into a sequence detector one step at a time
// and records the detector's response after each step.
module accu_seq_ctrl
  import accu_pkg::*;
#(
  parameter int NEXT_HIGH     = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] pattern,
  input  logic [4:0]  length,
  output logic        det_reset,
  output logic        det_in,
  output logic        det_next,
  input  logic        det_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] match_map,
  output logic [4:0]  match_count
);

  localparam logic [TW-1:0] RSTD_LD   = TW'(RSTD_LEN - 1);
  localparam logic [TW-1:0] PULSE_LD  = TW'(NEXT_HIGH - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);

  state_t state, state_nx;

  logic [15:0]   pat_q;
  logic [4:0]    len_q;
  logic [3:0]    k_q;
  logic          abort_q;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          latch;
  logic          capture;
  logic          step_inc;
  logic          abort_go;
  logic          last_step;

  assign last_step = ({1'b0, k_q} == (len_q - 5'd1));

  accu_step_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = RSTD_LD;
    latch    = 1'b0;
    capture  = 1'b0;
    step_inc = 1'b0;
    abort_go = 1'b0;
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      abort_go = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            latch    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = RSTD_LD;
            state_nx = RSTD;
          end
        end
        RSTD: begin
          if (tmr_zero)
            state_nx = (len_q == 5'd0) ? DONE : SETUP;
        end
        SETUP: begin
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
          state_nx = PULSE;
        end
        PULSE: begin
          if (tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LD;
            state_nx = SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_zero) begin
            capture = 1'b1;
            if (last_step) begin
              state_nx = DONE;
            end else begin
              step_inc = 1'b1;
              state_nx = SETUP;
            end
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs decode from state; the detector also resets with the controller
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    det_next  = (state == PULSE);
    det_in    = 1'b0;
    det_reset = reset || abort_q || (state == RSTD);
    unique case (1'b1)
      (state == SETUP),
      (state == PULSE),
      (state == SETTLE): det_in = pat_q[k_q];
      default:           det_in = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q       <= '0;
      len_q       <= '0;
      k_q         <= '0;
      abort_q     <= 1'b0;
      match_map   <= '0;
      match_count <= '0;
    end else begin
      abort_q <= abort_go;
      if (latch) begin
        pat_q       <= pattern;
        len_q       <= clamp_len(length);
        k_q         <= '0;
        match_map   <= '0;
        match_count <= '0;
      end
      if (capture) begin
        match_map[k_q] <= det_out;
        if (det_out && match_count != 5'(MAX_LEN))
          match_count <= match_count + 5'd1;
      end
      if (step_inc)
        k_q <= k_q + 4'd1;
    end
  end

endmodule

// File: tb/tb_accu_seq_ctrl.sv
// Scoreboard bench for accu_seq_ctrl with a registered detector model.
// Driver pushes expected pulses/results; a monitor pops and compares.
module tb_accu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic        det_reset;
  logic        det_in;
  logic        det_next;
  logic        det_out;
  logic        busy;
  logic        done;
  logic [15:0] match_map;
  logic [4:0]  match_count;

  typedef struct {
    int          lat;
    logic [15:0] map;
    logic [4:0]  cnt;
  } exp_t;

  exp_t done_q[$];
  logic bit_q[$];

  int cyc = 0;
  int t0  = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic nq = 1'b0;

  accu_seq_ctrl #(.NEXT_HIGH(2), .SETTLE_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .pattern     (pattern),
    .length      (length),
    .det_reset   (det_reset),
    .det_in      (det_in),
    .det_next    (det_next),
    .det_out     (det_out),
    .busy        (busy),
    .done        (done),
    .match_map   (match_map),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Detector model: capture det_in on each det_next rising edge
  always @(posedge clk) begin
    if (det_reset)
      det_out <= 1'b0;
    else if (det_next && !nq)
      det_out <= det_in;
    nq <= det_next;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor
  initial begin : mon
    logic prev;
    exp_t e;
    logic b;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (det_next === 1'b1 && prev !== 1'b1) begin
        if (bit_q.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          b = bit_q.pop_front();
          chk("det_in_at_pulse", 32'(det_in), 32'(b));
        end
      end
      prev = det_next;
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = done_q.pop_front();
          chk("latency", 32'(cyc - t0 + 1), 32'(e.lat));
          chk("match_map", 32'(match_map), 32'(e.map));
          chk("match_count", 32'(match_count), 32'(e.cnt));
        end
      end
    end
  end

  task automatic push_bits(input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) bit_q.push_back(b[i]);
  endtask

  task automatic push_done(input int lat, input logic [15:0] m,
                           input logic [4:0] c);
    exp_t e;
    e.lat = lat;
    e.map = m;
    e.cnt = c;
    done_q.push_back(e);
  endtask

  task automatic kick(input logic [15:0] p, input logic [4:0] l);
    @(negedge clk);
    pattern = p;
    length  = l;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    chk("rstd_c0", 32'(det_reset), 32'd1);
    chk("busy_c0", 32'(busy), 32'd1);
    @(negedge clk);
    chk("rstd_c1", 32'(det_reset), 32'd1);
    @(negedge clk);
    chk("rstd_end", 32'(det_reset), 32'd0);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    length  = '0;
    repeat (3) @(negedge clk);
    chk("rst_det_reset", 32'(det_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_det_next", 32'(det_next), 32'd0);
    chk("rst_det_in", 32'(det_in), 32'd0);
    chk("rst_map", 32'(match_map), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_det_reset", 32'(det_reset), 32'd0);

    // abort alone and abort+start in IDLE do nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("idle_abort_dreset", 32'(det_reset), 32'd0);
    pattern = 16'h0FA9;
    length  = 5'd12;
    start   = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);

    // 12-bit run with start/pattern noise while busy
    push_bits(16'h0FA9, 12);
    push_done(63, 16'h0FA9, 5'd8);
    kick(16'h0FA9, 5'd12);
    wait_cyc(t0 + 10);
    pattern = 16'hFFFF;
    length  = 5'd3;
    start   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // zero length
    push_done(3, 16'h0000, 5'd0);
    kick(16'hFFFF, 5'd0);
    wait_idle();

    // length clamp
    push_bits(16'hFFFF, 16);
    push_done(83, 16'hFFFF, 5'd16);
    kick(16'hFFFF, 5'd20);
    wait_idle();

    // abort during step 3 PULSE
    push_bits(16'h0FA9, 4);
    kick(16'h0FA9, 5'd12);
    wait_cyc(t0 + 18);
    chk("abort_in_pulse", 32'(det_next), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_det_reset", 32'(det_reset), 32'd1);
    chk("abort_map", 32'(match_map), 32'h0001);
    chk("abort_count", 32'(match_count), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("abort_dreset_end", 32'(det_reset), 32'd0);

    // reset during SETTLE of step 2
    push_bits(16'h00F3, 3);
    kick(16'h00F3, 5'd8);
    wait_cyc(t0 + 15);
    reset = 1'b1;
    #1;
    chk("mid_rst_dreset", 32'(det_reset), 32'd1);
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_next", 32'(det_next), 32'd0);
    chk("mid_rst_in", 32'(det_in), 32'd0);
    chk("mid_rst_map", 32'(match_map), 32'd0);
    chk("mid_rst_count", 32'(match_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_dreset", 32'(det_reset), 32'd0);

    // normal run after reset
    push_bits(16'h00F3, 8);
    push_done(43, 16'h00F3, 5'd6);
    kick(16'h00F3, 5'd8);
    wait_idle();
    repeat (3) @(negedge clk);

    chk("pulses_left", 32'(bit_q.size()), 32'd0);
    chk("dones_left", 32'(done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
